// File: rtl/seg_scan_capture_if.sv
// Scan-line bundle for the 7-segment capture block: the active-low an/seg
// lines driven by a display scanner plus the rebuilt frame outputs.
interface seg_scan_capture_if;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] value;
  logic [3:0]  blank;
  logic        valid;
  logic        frame_err;
  logic [7:0]  err_cnt;
  logic        stale;

  modport master (
    output an, seg,
    input  value, blank, valid, frame_err, err_cnt, stale
  );

  modport slave (
    input  an, seg,
    output value, blank, valid, frame_err, err_cnt, stale
  );
endinterface

// File: rtl/seg_scan_capture.sv
// Receiver for a multiplexed 4-digit active-low 7-segment scan. Debounces
// the (an,seg) lines, decodes each dwell to a nibble, checks digit order
// and publishes one 16-bit value per complete scan frame.
module seg_scan_capture #(
  parameter int unsigned STABLE  = 4,
  parameter int unsigned TIMEOUT = 2000000
) (
  input logic              clk,
  input logic              rstn,
  seg_scan_capture_if.slave scan
);

  localparam int unsigned SW      = $clog2(STABLE + 1);
  localparam logic [20:0] TO_LAST = 21'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, ERR} state_t;

  logic [3:0]       r_an_s1, r_an_s2;
  logic [6:0]       r_seg_s1, r_seg_s2;
  logic [10:0]      r_prev;
  logic [SW-1:0]    r_stab;
  logic             r_acc;
  logic [10:0]      r_dwell;
  logic [10:0]      w_samp;

  state_t           r_state, w_state_nxt;
  logic [3:0][3:0]  r_nib;
  logic [3:0]       r_seen;
  logic [1:0]       r_last;
  logic [15:0]      r_value;
  logic [3:0]       r_blank;
  logic             r_valid, r_ferr, r_stale;
  logic [7:0]       r_err_cnt;
  logic [20:0]      r_to;

  logic [3:0]       w_nib;
  logic             w_seg_ok, w_one, w_blank_slot, w_dig_ok, w_d0;
  logic [1:0]       w_idx;
  logic             w_load0, w_store, w_publish, w_fault;
  logic [15:0]      w_pub_val;

  assign w_samp = {r_an_s2, r_seg_s2};

  // Two-flop synchronizer, stability counter and single-shot dwell accept.
  // A sample equal to the last accepted dwell is not accepted again, so a
  // short glitch inside one dwell cannot make the same digit appear twice.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_an_s1  <= '1;
      r_an_s2  <= '1;
      r_seg_s1 <= '1;
      r_seg_s2 <= '1;
      r_prev   <= '1;
      r_stab   <= '0;
      r_acc    <= 1'b0;
      r_dwell  <= '1;
    end else begin
      r_an_s1  <= scan.an;
      r_an_s2  <= r_an_s1;
      r_seg_s1 <= scan.seg;
      r_seg_s2 <= r_seg_s1;
      r_prev   <= w_samp;
      r_acc    <= 1'b0;
      if (w_samp != r_prev)
        r_stab <= '0;
      else if (r_stab != SW'(STABLE))
        r_stab <= r_stab + 1'b1;
      if ((w_samp == r_prev) && (r_stab == SW'(STABLE - 2)) && (w_samp != r_dwell)) begin
        r_acc   <= 1'b1;
        r_dwell <= w_samp;
      end
    end
  end

  // Classify the accepted dwell: anode one-hot index and segment decode.
  always_comb begin
    w_nib    = 4'h0;
    w_seg_ok = 1'b1;
    unique case (r_dwell[6:0])
      7'b0000001: w_nib = 4'h0;
      7'b1001111: w_nib = 4'h1;
      7'b0010010: w_nib = 4'h2;
      7'b0000110: w_nib = 4'h3;
      7'b1001100: w_nib = 4'h4;
      7'b0100100: w_nib = 4'h5;
      7'b0100000: w_nib = 4'h6;
      7'b0001111: w_nib = 4'h7;
      7'b0000000: w_nib = 4'h8;
      7'b0000100: w_nib = 4'h9;
      7'b0001000: w_nib = 4'hA;
      7'b1100000: w_nib = 4'hB;
      7'b0110001: w_nib = 4'hC;
      7'b1000010: w_nib = 4'hD;
      7'b0110000: w_nib = 4'hE;
      7'b0111000: w_nib = 4'hF;
      default:    w_seg_ok = 1'b0;
    endcase
    w_idx = 2'd0;
    w_one = 1'b1;
    unique case (r_dwell[10:7])
      4'b1110: w_idx = 2'd0;
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: w_one = 1'b0;
    endcase
    w_blank_slot = (r_dwell[10:7] == 4'b1111);
    w_dig_ok     = w_one && w_seg_ok;
    w_d0         = r_acc && w_dig_ok && (w_idx == 2'd0);
  end

  // Frame FSM: next state and datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_load0     = 1'b0;
    w_store     = 1'b0;
    w_publish   = 1'b0;
    w_fault     = 1'b0;
    if (r_acc && !w_blank_slot) begin
      unique case (r_state)
        COLLECT: begin
          if (!w_dig_ok) begin
            w_fault     = 1'b1;
            w_state_nxt = ERR;
          end else if (w_idx == 2'd0) begin
            w_publish = 1'b1;
            w_load0   = 1'b1;
          end else if (w_idx > r_last) begin
            w_store = 1'b1;
          end else begin
            w_fault     = 1'b1;
            w_state_nxt = ERR;
          end
        end
        default: begin
          if (w_dig_ok && (w_idx == 2'd0)) begin
            w_load0     = 1'b1;
            w_state_nxt = COLLECT;
          end
        end
      endcase
    end
  end

  // Published value: digits never seen in the frame read as zero.
  always_comb begin
    w_pub_val = '0;
    for (int unsigned i = 0; i < 4; i++)
      if (r_seen[i])
        w_pub_val[4*i +: 4] = r_nib[i];
  end

  // State register, frame collection, publish/error outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_nib     <= '0;
      r_seen    <= '0;
      r_last    <= '0;
      r_value   <= '0;
      r_blank   <= '1;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_publish;
      r_ferr  <= w_fault;
      if (w_publish) begin
        r_value <= w_pub_val;
        r_blank <= {~r_seen[3:1], 1'b0};
      end
      if (w_load0) begin
        r_nib[0] <= w_nib;
        r_seen   <= 4'b0001;
        r_last   <= 2'd0;
      end
      if (w_store) begin
        r_nib[w_idx]  <= w_nib;
        r_seen[w_idx] <= 1'b1;
        r_last        <= w_idx;
      end
      if (w_fault && (r_err_cnt != '1))
        r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  // Stale watchdog: restarted by every accepted valid digit 0.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_to    <= '0;
      r_stale <= 1'b0;
    end else if (w_d0) begin
      r_to    <= '0;
      r_stale <= 1'b0;
    end else if (r_to != TO_LAST) begin
      r_to <= r_to + 1'b1;
      if (r_to == TO_LAST - 1'b1)
        r_stale <= 1'b1;
    end
  end

  assign scan.value     = r_value;
  assign scan.blank     = r_blank;
  assign scan.valid     = r_valid;
  assign scan.frame_err = r_ferr;
  assign scan.err_cnt   = r_err_cnt;
  assign scan.stale     = r_stale;

endmodule
